// File: rtl/rv32i_pkg.sv
// Shared RV32I decode encodings: opcodes, ALUOp/WriteBack/ImmControl codes
// and the ID/EX control word with its bubble value.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] WB_ALU   = 3'b000;
  localparam logic [2:0] WB_MEM   = 3'b001;
  localparam logic [2:0] WB_PC4   = 3'b010;
  localparam logic [2:0] WB_LUI   = 3'b011;
  localparam logic [2:0] WB_AUIPC = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       jump;
    logic       branch;
    logic       muxjalr;
    logic [3:0] alu_op;
    logic [2:0] write_back;
    logic [2:0] funct3;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection and front-end stall generation.
// Kept standalone so the forwarding unit can share the same compare.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ValidE,
  input  logic              MemReadE,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ValidD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              FlushE,
  input  logic              StallE,
  output logic              ldu,
  output logic              StallF,
  output logic              StallD
);

  // Rs2D is compared for every format; an I-type false stall is harmless.
  assign ldu = ValidE & MemReadE & (RdE != '0) & ValidD &
               ((RdE == Rs1D) | (RdE == Rs2D));

  assign StallF = StallE | (ldu & ~FlushE);
  assign StallD = StallF;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and flush.
// Optional IDEX_PERF_CNT_EN adds BubbleCnt/StallCnt event counters.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemReadD,
  input  logic              MemWriteD,
  input  logic              ALUSrcD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              MuxjalrD,
  input  logic [3:0]        ALUOpD,
  input  logic [2:0]        WriteBackD,
  input  logic [2:0]        funct3D,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemReadE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              MuxjalrE,
  output logic [3:0]        ALUOpE,
  output logic [2:0]        WriteBackE,
  output logic [2:0]        funct3E,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]       BubbleCnt,
  output logic [31:0]       StallCnt,
`endif
  output logic              StallF,
  output logic              StallD
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_e;
  logic  ldu;
  logic  load_bubble;

  assign ctrl_d = '{reg_write:  RegWriteD,
                    mem_read:   MemReadD,
                    mem_write:  MemWriteD,
                    alu_src:    ALUSrcD,
                    jump:       JumpD,
                    branch:     BranchD,
                    muxjalr:    MuxjalrD,
                    alu_op:     ALUOpD,
                    write_back: WriteBackD,
                    funct3:     funct3D};

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ValidE   (ValidE),
    .MemReadE (ctrl_e.mem_read),
    .RdE      (RdE),
    .ValidD   (ValidD),
    .Rs1D     (Rs1D),
    .Rs2D     (Rs2D),
    .FlushE   (FlushE),
    .StallE   (StallE),
    .ldu      (ldu),
    .StallF   (StallF),
    .StallD   (StallD)
  );

  assign load_bubble = FlushE | ldu;

  // StallE outranks FlushE: the EX owner holds FlushE until the hold drops.
  always_ff @(posedge clk) begin
    if (rst || (!StallE && load_bubble)) begin
      ctrl_e   <= CTRL_BUBBLE;
      ValidE   <= 1'b0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (!StallE) begin
      ctrl_e   <= ctrl_d;
      ValidE   <= ValidD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
    end
  end

  assign RegWriteE  = ctrl_e.reg_write;
  assign MemReadE   = ctrl_e.mem_read;
  assign MemWriteE  = ctrl_e.mem_write;
  assign ALUSrcE    = ctrl_e.alu_src;
  assign JumpE      = ctrl_e.jump;
  assign BranchE    = ctrl_e.branch;
  assign MuxjalrE   = ctrl_e.muxjalr;
  assign ALUOpE     = ctrl_e.alu_op;
  assign WriteBackE = ctrl_e.write_back;
  assign funct3E    = ctrl_e.funct3;

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      BubbleCnt <= '0;
      StallCnt  <= '0;
    end else begin
      if (StallE)
        StallCnt <= StallCnt + 32'd1;
      if (!StallE && load_bubble)
        BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the RV32I 5-stage core.
- Registers the decode-stage control word and operand data into the execute stage.
- Detects load-use hazards against the instruction already in EX. On a hazard it raises StallF/StallD and inserts a bubble.
- Handles execute-side hold (StallE) and branch/jump flush (FlushE).

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- StallE  in  1  hold EX register (downstream memory wait)
- FlushE  in  1  branch/jump taken in EX; bubble EX next edge
- ValidD  in  1  D holds a real instruction
- RegWriteD, MemReadD, MemWriteD, ALUSrcD, JumpD, BranchD, MuxjalrD  in  1 each  decode control
- ALUOpD  in  4  ALU operation
- WriteBackD  in  3  writeback select
- funct3D  in  3  branch/load-width qualifier
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands / PC values
- Rs1D, Rs2D, RdD  in  REG_AW each  register addresses
- (all *D control/data above mirrored as *E outputs, same widths)  out  registered EX copies
- ValidE  out  1  EX holds a real instruction
- StallF, StallD  out  1 each  hold PC and IF/ID register

Behaviour:
- Reset (rst=1 at posedge):
  - all *E outputs = 0, ValidE = 0.
  - StallF/StallD follow the combinational rule below and therefore read 0 after reset.
- Load-use hazard, combinational:
  - ldu = ValidE & MemReadE & (RdE != 0) & ValidD & (RdE == Rs1D | RdE == Rs2D).
  - Rs2D is compared regardless of format; a false stall on I-type is accepted.
- StallF = StallD = StallE | (ldu & ~FlushE).
- Next-state priority at each posedge: rst > StallE > FlushE > ldu > capture.
  - StallE=1: every E register holds, including while FlushE=1. The flush is not lost: the EX owner keeps FlushE asserted until StallE drops.
  - FlushE=1: bubble.
  - ldu=1: bubble. The D instruction is held upstream and captured on the next edge, because MemReadE is then 0 and ldu clears. Load-use costs exactly 1 bubble.
  - Else capture: every *E <= *D, ValidE <= ValidD.
- Bubble definition:
  - ValidE=0; RegWriteE, MemReadE, MemWriteE, JumpE, BranchE, MuxjalrE = 0.
  - ALUOpE=0000, WriteBackE=000.
  - Data/address fields cleared to 0, so RdE=0 and no forwarding match occurs.
- Captured ValidD=0: control is stored as presented. Downstream qualifies all side effects with ValidE.
- Latency: D to E is 1 cycle, with no combinational path D to E outputs.
- Only combinational outputs are StallF/StallD; they depend on E registers plus Rs1D/Rs2D/ValidD/FlushE/StallE.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: adds outputs BubbleCnt[31:0] and StallCnt[31:0].
  - BubbleCnt increments on every edge that loads a bubble (FlushE or ldu, StallE=0).
  - StallCnt increments on every edge where StallE=1.
  - Both are free-running, wrap 0xFFFFFFFF -> 0, and clear on rst.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package rv32i_pkg:
  - opcode constants.
  - ALUOp encodings 0000..1001.
  - WriteBack encodings: 000 ALU, 001 mem, 010 PC+4, 011 LUI, 100 AUIPC.
  - ImmControl encodings.
  - Bubble control-word constant.
- Sub-module hazard_detect: combinational ldu/StallF/StallD generation, reused later by the forwarding unit.
- Register bank lives in id_ex_stage.

Test Plan:
- Reset: drive rst=1 with all *D=1s for 2 cycles -> all *E=0, ValidE=0, StallD=0. After release, first edge captures D.
- Load-use: EX holds lw x5 (MemReadE=1, RdE=5, ValidE=1), D has add x6,x5,x7 (Rs1D=5) -> StallF=StallD=1 that cycle; next edge bubble (ValidE=0, RegWriteE=0); following edge captures add with RdE=6.
- No hazard on x0: lw x0 in EX, Rs1D=0 -> StallD=0, straight capture.
- Flush + ldu together: FlushE=1 while ldu conditions hold -> StallD=0, bubble loaded, BubbleCnt +1 (if enabled).
- StallE hold: StallE=1 for 3 cycles with changing *D -> *E constant, StallF=StallD=1. With FlushE=1 also asserted and then kept high after StallE drops, the next edge after StallE drops yields the bubble.
- Perf wrap (IDEX_PERF_CNT_EN): preload BubbleCnt via force to 0xFFFFFFFF, apply FlushE -> BubbleCnt=0.
